// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates tags at dispatch, captures out-of-order ALU/MUL results,
// and retires entries strictly in program order onto the register-bank write port.
module reorder_buffer #(
    parameter int REG_ADDRESS_SIZE = 5,
    parameter int REG_SIZE         = 32,
    parameter int ID_SIZE          = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        RB_alloc,
    input  logic [REG_ADDRESS_SIZE-1:0] RB_dest,
    input  logic                        RB_w,
    input  logic                        RB_alu_valid,
    input  logic [ID_SIZE-1:0]          RB_alu_id,
    input  logic [REG_SIZE-1:0]         RB_alu_value,
    input  logic                        RB_mul_valid,
    input  logic [ID_SIZE-1:0]          RB_mul_id,
    input  logic [REG_SIZE-1:0]         RB_mul_value,
    output logic                        RB_stall,
    output logic [ID_SIZE-1:0]          RB_tail,
    output logic [REG_ADDRESS_SIZE-1:0] RB_Wat,
    output logic [REG_SIZE-1:0]         RB_Wvalue,
    output logic                        RB_We,
    output logic [ID_SIZE:0]            RB_count
);

    localparam int ENTRIES = 1 << ID_SIZE;
    localparam logic [ID_SIZE:0] FULL_COUNT = {1'b1, {ID_SIZE{1'b0}}};

    logic [ENTRIES-1:0]          busy;
    logic [ENTRIES-1:0]          done;
    logic [ENTRIES-1:0]          w_flag;
    logic [REG_ADDRESS_SIZE-1:0] dest  [ENTRIES];
    logic [REG_SIZE-1:0]         value [ENTRIES];

    logic [ID_SIZE-1:0] head;
    logic [ID_SIZE-1:0] tail;
    logic [ID_SIZE:0]   count;

    logic               alloc_fire;
    logic               retire_fire;
    logic [ENTRIES-1:0] alu_hit;
    logic [ENTRIES-1:0] mul_hit;

    assign RB_stall    = (count == FULL_COUNT);
    assign alloc_fire  = RB_alloc && !RB_stall;
    assign retire_fire = (count != '0) && done[head];
    assign RB_tail     = tail;
    assign RB_count    = count;

    // Completions only land on entries that are currently in flight.
    always_comb begin
        alu_hit = '0;
        mul_hit = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            alu_hit[i] = RB_alu_valid && (RB_alu_id == ID_SIZE'(i)) && busy[i];
            mul_hit[i] = RB_mul_valid && (RB_mul_id == ID_SIZE'(i)) && busy[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc_fire) begin
                tail <= tail + 1'b1;
            end
            if (retire_fire) begin
                head <= head + 1'b1;
            end
            case ({alloc_fire, retire_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Later assignments take priority: retire clears, then a fresh allocation claims the slot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy <= '0;
            done <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (alu_hit[i] || mul_hit[i]) begin
                    done[i] <= 1'b1;
                end
                if (retire_fire && (head == ID_SIZE'(i))) begin
                    busy[i] <= 1'b0;
                    done[i] <= 1'b0;
                end
                if (alloc_fire && (tail == ID_SIZE'(i))) begin
                    busy[i] <= 1'b1;
                    done[i] <= 1'b0;
                end
            end
        end
    end

    // Payload needs no reset; busy/done gate every use. ALU overrides MUL on a tag collision.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (mul_hit[i]) begin
                value[i] <= RB_mul_value;
            end
            if (alu_hit[i]) begin
                value[i] <= RB_alu_value;
            end
            if (alloc_fire && (tail == ID_SIZE'(i))) begin
                dest[i]   <= RB_dest;
                w_flag[i] <= RB_w;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            RB_We     <= 1'b0;
            RB_Wat    <= '0;
            RB_Wvalue <= '0;
        end else if (retire_fire) begin
            RB_We     <= w_flag[head];
            RB_Wat    <= dest[head];
            RB_Wvalue <= value[head];
        end else begin
            RB_We <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected register writes are queued at dispatch
// and a negedge monitor matches every RB_We pulse against them in program order.
module tb_reorder_buffer;

    localparam int RA = 5;
    localparam int RS = 32;
    localparam int IS = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          RB_alloc;
    logic [RA-1:0] RB_dest;
    logic          RB_w;
    logic          RB_alu_valid;
    logic [IS-1:0] RB_alu_id;
    logic [RS-1:0] RB_alu_value;
    logic          RB_mul_valid;
    logic [IS-1:0] RB_mul_id;
    logic [RS-1:0] RB_mul_value;
    logic          RB_stall;
    logic [IS-1:0] RB_tail;
    logic [RA-1:0] RB_Wat;
    logic [RS-1:0] RB_Wvalue;
    logic          RB_We;
    logic [IS:0]   RB_count;

    typedef struct packed {
        logic [RA-1:0] addr;
        logic [RS-1:0] data;
    } wr_t;

    wr_t           expq[$];
    int            checks = 0;
    int            errors = 0;
    logic [IS-1:0] model_tail;
    logic [IS-1:0] ids [22];

    reorder_buffer #(.REG_ADDRESS_SIZE(RA), .REG_SIZE(RS), .ID_SIZE(IS)) dut (
        .clk(clk), .reset(reset),
        .RB_alloc(RB_alloc), .RB_dest(RB_dest), .RB_w(RB_w),
        .RB_alu_valid(RB_alu_valid), .RB_alu_id(RB_alu_id), .RB_alu_value(RB_alu_value),
        .RB_mul_valid(RB_mul_valid), .RB_mul_id(RB_mul_id), .RB_mul_value(RB_mul_value),
        .RB_stall(RB_stall), .RB_tail(RB_tail), .RB_Wat(RB_Wat),
        .RB_Wvalue(RB_Wvalue), .RB_We(RB_We), .RB_count(RB_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic alloc, input logic [RA-1:0] dest, input logic w,
                                 input logic av, input logic [IS-1:0] aid, input logic [RS-1:0] aval,
                                 input logic mv, input logic [IS-1:0] mid, input logic [RS-1:0] mval);
        RB_alloc = alloc;  RB_dest = dest;  RB_w = w;
        RB_alu_valid = av; RB_alu_id = aid; RB_alu_value = aval;
        RB_mul_valid = mv; RB_mul_id = mid; RB_mul_value = mval;
        tick();
        RB_alloc = 1'b0; RB_dest = '0; RB_w = 1'b0;
        RB_alu_valid = 1'b0; RB_alu_id = '0; RB_alu_value = '0;
        RB_mul_valid = 1'b0; RB_mul_id = '0; RB_mul_value = '0;
    endtask

    task automatic doAlloc(input logic [RA-1:0] dest, input logic w, input logic [RS-1:0] val);
        checkOutput("tail_before_alloc", 64'(RB_tail), 64'(model_tail));
        if (w) expq.push_back('{addr: dest, data: val});
        applyStimulus(1'b1, dest, w, 1'b0, '0, '0, 1'b0, '0, '0);
        model_tail = model_tail + 1'b1;
    endtask

    task automatic complete(input logic [IS-1:0] id, input logic [RS-1:0] val);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, id, val, 1'b0, '0, '0);
    endtask

    task automatic resetDut();
        checkOutput("queue_drained_before_reset", 64'(expq.size()), 64'd0);
        expq.delete();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        model_tail = '0;
    endtask

    task automatic waitDrain(input int limit);
        int n = 0;
        while (RB_count != '0 && n < limit) begin
            tick();
            n++;
        end
        checkOutput("drain_count", 64'(RB_count), 64'd0);
        tick();
    endtask

    // Monitor: every write-enable cycle must match the oldest outstanding expectation.
    initial begin
        wr_t exp_wr;
        forever begin
            @(negedge clk);
            if (RB_We === 1'b1) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write actual=%0h:%0h required=none", RB_Wat, RB_Wvalue);
                end else begin
                    exp_wr = expq.pop_front();
                    checkOutput("retire_addr", 64'(RB_Wat), 64'(exp_wr.addr));
                    checkOutput("retire_data", 64'(RB_Wvalue), 64'(exp_wr.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0;
        RB_alloc = 1'b0; RB_dest = '0; RB_w = 1'b0;
        RB_alu_valid = 1'b0; RB_alu_id = '0; RB_alu_value = '0;
        RB_mul_valid = 1'b0; RB_mul_id = '0; RB_mul_value = '0;
        model_tail = '0;
        tick();
        tick();
        checkOutput("reset_count", 64'(RB_count), 64'd0);
        checkOutput("reset_tail", 64'(RB_tail), 64'd0);
        checkOutput("reset_stall", 64'(RB_stall), 64'd0);
        checkOutput("reset_we", 64'(RB_We), 64'd0);
        checkOutput("reset_wat", 64'(RB_Wat), 64'd0);
        checkOutput("reset_wvalue", 64'(RB_Wvalue), 64'd0);
        reset = 1'b1;
        tick();

        $display("[TB] out-of-order completion, in-order retire");
        doAlloc(5'd1, 1'b1, 32'hA);
        doAlloc(5'd2, 1'b1, 32'hB);
        doAlloc(5'd3, 1'b1, 32'hC);
        checkOutput("t1_tail", 64'(RB_tail), 64'd3);
        checkOutput("t1_count", 64'(RB_count), 64'd3);
        complete(3'd2, 32'hC);
        checkOutput("t1_no_early_we_a", 64'(RB_We), 64'd0);
        tick();
        checkOutput("t1_no_early_we_b", 64'(RB_We), 64'd0);
        complete(3'd0, 32'hA);
        checkOutput("t1_we_low_on_done_edge", 64'(RB_We), 64'd0);
        complete(3'd1, 32'hB);
        checkOutput("t1_first_we", 64'(RB_We), 64'd1);
        checkOutput("t1_first_wat", 64'(RB_Wat), 64'd1);
        checkOutput("t1_first_wvalue", 64'(RB_Wvalue), 64'hA);
        checkOutput("t1_count_after_retire", 64'(RB_count), 64'd2);
        waitDrain(10);

        $display("[TB] full buffer stall");
        resetDut();
        for (int i = 0; i < 8; i++) doAlloc(5'(8 + i), 1'b1, 32'(32'h100 + i));
        checkOutput("t2_stall_full", 64'(RB_stall), 64'd1);
        checkOutput("t2_count_full", 64'(RB_count), 64'd8);
        applyStimulus(1'b1, 5'd31, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("t2_ninth_tail", 64'(RB_tail), 64'd0);
        checkOutput("t2_ninth_count", 64'(RB_count), 64'd8);
        complete(3'd0, 32'h100);
        checkOutput("t2_stall_after_done", 64'(RB_stall), 64'd1);
        applyStimulus(1'b1, 5'd30, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("t2_stall_after_retire", 64'(RB_stall), 64'd0);
        checkOutput("t2_count_after_retire", 64'(RB_count), 64'd7);
        checkOutput("t2_tail_held", 64'(RB_tail), 64'd0);
        doAlloc(5'd20, 1'b1, 32'h1FF);
        checkOutput("t2_refill_count", 64'(RB_count), 64'd8);
        for (int i = 1; i < 8; i++) complete(3'(i), 32'(32'h100 + i));
        complete(3'd0, 32'h1FF);
        waitDrain(20);

        $display("[TB] simultaneous ALU and MUL completion");
        resetDut();
        doAlloc(5'd10, 1'b1, 32'd5);
        doAlloc(5'd11, 1'b1, 32'd7);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 3'd0, 32'd5, 1'b1, 3'd1, 32'd7);
        checkOutput("t3_we_low", 64'(RB_We), 64'd0);
        tick();
        checkOutput("t3_we_first", 64'(RB_We), 64'd1);
        checkOutput("t3_wat_first", 64'(RB_Wat), 64'd10);
        checkOutput("t3_wvalue_first", 64'(RB_Wvalue), 64'd5);
        tick();
        checkOutput("t3_wat_second", 64'(RB_Wat), 64'd11);
        checkOutput("t3_wvalue_second", 64'(RB_Wvalue), 64'd7);
        checkOutput("t3_count", 64'(RB_count), 64'd0);
        tick();

        $display("[TB] silent retire of non-writing entry");
        doAlloc(5'd12, 1'b0, 32'h0);
        checkOutput("t4_count_alloc", 64'(RB_count), 64'd1);
        complete(3'd2, 32'h99);
        checkOutput("t4_count_done", 64'(RB_count), 64'd1);
        tick();
        checkOutput("t4_count_retired", 64'(RB_count), 64'd0);
        checkOutput("t4_we_silent", 64'(RB_We), 64'd0);
        checkOutput("t4_tail", 64'(RB_tail), 64'd3);

        $display("[TB] steady alloc and retire with pointer wrap");
        for (int k = 0; k < 22; k++) begin
            ids[k] = model_tail;
            checkOutput("t5_tail", 64'(RB_tail), 64'(model_tail));
            expq.push_back('{addr: 5'(k + 1), data: 32'(32'h200 + k)});
            if (k > 0) applyStimulus(1'b1, 5'(k + 1), 1'b1, 1'b1, ids[k-1], 32'(32'h200 + k - 1), 1'b0, '0, '0);
            else       applyStimulus(1'b1, 5'(k + 1), 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
            model_tail = model_tail + 1'b1;
            if (k >= 2) checkOutput("t5_steady_count", 64'(RB_count), 64'd2);
        end
        complete(ids[21], 32'(32'h200 + 21));
        waitDrain(10);

        $display("[TB] reset flushes in-flight entries");
        resetDut();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 5'(16 + i), 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("t6_count_busy", 64'(RB_count), 64'd4);
        complete(3'd0, 32'h55);
        reset = 1'b0;
        tick();
        checkOutput("t6_count_reset", 64'(RB_count), 64'd0);
        checkOutput("t6_we_reset", 64'(RB_We), 64'd0);
        checkOutput("t6_tail_reset", 64'(RB_tail), 64'd0);
        reset = 1'b1;
        model_tail = '0;
        complete(3'd1, 32'h66);
        checkOutput("t6_late_count", 64'(RB_count), 64'd0);
        checkOutput("t6_late_we", 64'(RB_We), 64'd0);
        tick();
        checkOutput("t6_late_we_next", 64'(RB_We), 64'd0);
        doAlloc(5'd20, 1'b1, 32'h77);
        doAlloc(5'd21, 1'b1, 32'h78);
        complete(3'd0, 32'h77);
        complete(3'd1, 32'h78);
        waitDrain(10);

        checkOutput("final_queue_empty", 64'(expq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
